// File: rtl/hurricane_scheduler.sv
// Hurricane (mode 3) episode sequencer: grants one timed run per power-on session
// and tells the mode FSM whether to drop back to level 2 or standby afterwards.
module hurricane_scheduler #(
  parameter int CLK_PER_SEC   = 100_000_000,
  parameter int HURRICANE_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic       countdown_active,
  output logic [7:0] remaining_sec
);

  localparam int            PW             = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST       = PW'(CLK_PER_SEC - 1);
  localparam logic [7:0]    RUN_SEC        = 8'(HURRICANE_SEC);
  localparam logic [2:0]    MODE_HURRICANE = 3'b011;

  typedef enum logic [1:0] {ARMED, RUN, EXIT, USED} state_t;

  state_t        state, state_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic [7:0]    remaining_next;
  logic          return_next;
  logic          menu_prev;
  logic          menu_rise;
  logic          in_hurricane;
  logic          tick;

  assign menu_rise    = menu_btn & ~menu_prev;
  assign in_hurricane = (mode_state == MODE_HURRICANE);
  assign tick         = (prescaler == PRE_LAST);

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    remaining_next = remaining_sec;
    return_next    = return_state;

    case (state)
      ARMED: begin
        if (in_hurricane) begin
          state_next     = RUN;
          prescaler_next = '0;
          remaining_next = RUN_SEC;
          return_next    = 1'b0;
        end
      end
      RUN: begin
        if (!in_hurricane) begin
          state_next     = USED;
          prescaler_next = '0;
          remaining_next = 8'd0;
          return_next    = 1'b0;
        end else begin
          prescaler_next = tick ? '0 : prescaler + PW'(1);
          if (tick && remaining_sec != 8'd0) begin
            remaining_next = remaining_sec - 8'd1;
            if (remaining_sec == 8'd1) begin
              state_next = EXIT;
            end
          end
          // A press on the final tick still counts: menu wins over expiry.
          if (menu_rise) begin
            return_next = 1'b1;
          end
        end
      end
      EXIT: begin
        // return_state must stay put until the mode FSM has actually left mode 3.
        if (!in_hurricane) begin
          state_next  = USED;
          return_next = 1'b0;
        end
      end
      USED: begin
        remaining_next = 8'd0;
        return_next    = 1'b0;
      end
      default: state_next = ARMED;
    endcase

    // Power-off behaves as a reset and re-arms the next session.
    if (!machine_state) begin
      state_next     = ARMED;
      prescaler_next = '0;
      remaining_next = 8'd0;
      return_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ARMED;
      prescaler     <= '0;
      remaining_sec <= 8'd0;
      return_state  <= 1'b0;
      menu_prev     <= 1'b0;
    end else begin
      state         <= state_next;
      prescaler     <= prescaler_next;
      remaining_sec <= remaining_next;
      return_state  <= return_next;
      menu_prev     <= menu_btn;
    end
  end

  assign hurricane_mode_enabled = (state == ARMED) || (state == RUN);
  assign countdown_active       = (state == RUN);

endmodule

// File: tb/tb_hurricane_scheduler.sv
// Scoreboard bench for hurricane_scheduler: directed test-plan sequences followed by
// randomized traffic, checked against an episode-level reference model.
`timescale 1ns/1ps
module tb_hurricane_scheduler;

  localparam int CPS   = 4;
  localparam int HSEC  = 3;
  localparam int TOTAL = CPS * HSEC;

  logic       clk;
  logic       rst;
  logic       machine_state;
  logic [2:0] mode_state;
  logic       menu_btn;
  logic       hurricane_mode_enabled;
  logic       return_state;
  logic       countdown_active;
  logic [7:0] remaining_sec;

  hurricane_scheduler #(.CLK_PER_SEC(CPS), .HURRICANE_SEC(HSEC)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .machine_state          (machine_state),
    .mode_state             (mode_state),
    .menu_btn               (menu_btn),
    .hurricane_mode_enabled (hurricane_mode_enabled),
    .return_state           (return_state),
    .countdown_active       (countdown_active),
    .remaining_sec          (remaining_sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    int         cyc;
    logic       en;
    logic       ret;
    logic       cnt;
    logic [7:0] rem;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model: one hurricane grant per session, timed by elapsed cycles.
  bit m_used, m_running, m_waiting, m_ret, m_prev;
  int m_elapsed;

  task automatic model_reset();
    m_used = 0; m_running = 0; m_waiting = 0; m_ret = 0; m_prev = 0; m_elapsed = 0;
  endtask

  task automatic model_step(input logic ms, input logic [2:0] mode, input logic menu);
    bit rise;
    rise   = menu && !m_prev;
    m_prev = menu;
    if (!ms) begin
      m_used = 0; m_running = 0; m_waiting = 0; m_ret = 0; m_elapsed = 0;
    end else if (m_running) begin
      if (mode != 3'd3) begin
        m_running = 0; m_ret = 0;
      end else begin
        m_elapsed++;
        if (rise) m_ret = 1;
        if (m_elapsed == TOTAL) begin
          m_running = 0; m_waiting = 1;
        end
      end
    end else if (m_waiting) begin
      if (mode != 3'd3) begin
        m_waiting = 0; m_ret = 0;
      end
    end else if (!m_used && mode == 3'd3) begin
      m_running = 1; m_used = 1; m_elapsed = 0; m_ret = 0;
    end
  endtask

  function automatic exp_t model_expect(input int cyc);
    exp_t e;
    e.cyc = cyc;
    e.en  = !m_used || m_running;
    e.ret = m_ret;
    e.cnt = m_running;
    e.rem = m_running ? 8'(HSEC - m_elapsed / CPS) : 8'd0;
    return e;
  endfunction

  task automatic compareOne(input string name, input int got, input int want);
    n_compared++;
    if (got != want) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycle_cnt, got, want);
    end
  endtask

  task automatic checkOutput(input logic en, input logic ret, input logic cnt, input logic [7:0] rem);
    compareOne("enabled",          hurricane_mode_enabled, en);
    compareOne("return_state",     return_state,           ret);
    compareOne("countdown_active", countdown_active,       cnt);
    compareOne("remaining_sec",    remaining_sec,          rem);
  endtask

  // Monitor: compares every expectation whose target edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
        e = sb.pop_front();
        checkOutput(e.en, e.ret, e.cnt, e.rem);
      end
    end
  end

  // Drives one cycle of inputs, predicts the post-edge outputs, then steps past the edge.
  task automatic applyStimulus(input logic ms, input logic [2:0] mode, input logic menu);
    machine_state = ms;
    mode_state    = mode;
    menu_btn      = menu;
    model_step(ms, mode, menu);
    sb.push_back(model_expect(cycle_cnt + 1));
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input logic ms, input logic [2:0] mode, input logic menu);
    for (int i = 0; i < n; i++) applyStimulus(ms, mode, menu);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int   mode_r;
    logic ms_r, menu_r;

    rst = 1'b0; machine_state = 1'b1; mode_state = 3'd0; menu_btn = 1'b0;
    model_reset();
    #3;
    checkOutput(1'b1, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    releaseReset();

    // Plain run to expiry, external exit to standby, refused second grant.
    runCycles(2, 1'b1, 3'd0, 1'b0);
    runCycles(TOTAL + 3, 1'b1, 3'd3, 1'b0);
    runCycles(3, 1'b1, 3'd2, 1'b0);
    runCycles(4, 1'b1, 3'd3, 1'b0);
    runCycles(2, 1'b0, 3'd3, 1'b0);
    runCycles(2, 1'b1, 3'd0, 1'b0);

    // Menu pulse at RUN cycle 5, then exit to level 2.
    applyStimulus(1'b1, 3'd3, 1'b0);
    for (int k = 1; k <= TOTAL + 2; k++) applyStimulus(1'b1, 3'd3, (k == 5));
    runCycles(3, 1'b1, 3'd2, 1'b0);

    // Menu rise coincident with the final prescaler tick.
    runCycles(2, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    for (int k = 1; k <= TOTAL + 2; k++) applyStimulus(1'b1, 3'd3, (k == TOTAL));
    runCycles(2, 1'b1, 3'd1, 1'b0);

    // Menu held since before RUN entry does not set return_state.
    runCycles(2, 1'b0, 3'd0, 1'b1);
    runCycles(TOTAL + 2, 1'b1, 3'd3, 1'b1);
    runCycles(2, 1'b1, 3'd0, 1'b0);

    // Power-off at RUN cycle 6.
    runCycles(2, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    runCycles(5, 1'b1, 3'd3, 1'b0);
    runCycles(2, 1'b0, 3'd3, 1'b0);
    runCycles(3, 1'b1, 3'd3, 1'b0);

    // Asynchronous reset mid-RUN, taken between clock edges.
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput(1'b1, 1'b0, 1'b0, 8'd0);
    releaseReset();
    runCycles(4, 1'b1, 3'd3, 1'b0);

    // Randomized traffic.
    mode_r = 0; ms_r = 1'b1; menu_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ms_r = ($urandom_range(49) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(15) == 0) mode_r = ($urandom_range(1) == 0) ? 3 : int'($urandom_range(7));
      if ($urandom_range(3) == 0) menu_r = ~menu_r;
      applyStimulus(ms_r, 3'(mode_r), menu_r);
    end

    repeat (2) @(negedge clk);
    #1;
    compareOne("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/hurricane_scheduler.md
Name: hurricane_scheduler

Overview:
- Sequences the hurricane (mode 3, mode_state 3'b011) episode of the range-hood controller.
- Grants hurricane once per power-on session and times the run in seconds.
- Tells the mode FSM when to leave mode 3 and where to go: level 2 if menu was pressed during the run, otherwise standby.
- Sits beside the mode FSM. Drives its hurricane_mode_enabled and return_state inputs, and drives remaining_sec to the display.

Parameters:
CLK_PER_SEC, 100_000_000, clock cycles per second tick (prescaler terminal count + 1)
HURRICANE_SEC, 60, hurricane run length in seconds (1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
machine_state  input  1  1 = hood powered on
mode_state  input  3  current mode from mode FSM (3'b011 = hurricane)
menu_btn  input  1  debounced menu button level
hurricane_mode_enabled  output  1  1 = mode 3 may be entered / may continue
return_state  output  1  1 = exit mode 3 to level 2; 0 = exit to standby
countdown_active  output  1  1 while hurricane timer is running
remaining_sec  output  8  seconds left in hurricane run (0 when not running)

Behaviour:
- Reset (rst=0, async): state=ARMED, hurricane_mode_enabled=1, return_state=0, countdown_active=0, remaining_sec=0, prescaler=0, menu_prev=0.
- Menu edge: menu_rise = menu_btn & ~menu_prev. menu_prev is registered every cycle.
- Power-off override: while machine_state=0, force state=ARMED. Outputs take their reset values, counters clear. This has priority over all transitions and serves as reset mid-operation.
- States: ARMED, RUN, EXIT, USED.
- ARMED:
  - enabled=1.
  - mode_state==3'b011 sampled → next cycle RUN, remaining_sec=HURRICANE_SEC, prescaler=0, countdown_active=1, return_state=0.
- RUN:
  - enabled=1.
  - Prescaler counts 0..CLK_PER_SEC-1 and wraps. At terminal count, remaining_sec decrements by 1.
  - When the decrement takes remaining_sec from 1 to 0, next state=EXIT. countdown_active clears the same edge.
  - Expiry occurs exactly HURRICANE_SEC*CLK_PER_SEC cycles after RUN entry.
  - menu_rise in RUN sets return_state=1. It is sticky; further presses have no effect.
  - mode_state leaves 3'b011 during RUN (external exit) → USED, remaining_sec=0, countdown_active=0, return_state=0.
- EXIT:
  - enabled=0, return_state held.
  - Wait for mode_state != 3'b011, then USED and return_state cleared on that edge.
  - The mode FSM consumes return_state in the cycle it sees enabled=0, so return_state must be stable from the EXIT entry edge until leaving EXIT.
- USED:
  - enabled=0, return_state=0, remaining_sec=0.
  - Holds until machine_state falls; power-off then re-arms.
  - A second hurricane in the same session is refused because enabled=0.
- Simultaneous menu_rise and final tick: return_state=1 is latched on the same edge as entry to EXIT (menu wins).
- menu_btn held across RUN entry: counts as a rise only if menu_prev was 0 in the previous cycle. A button held since before RUN does not set return_state.
- Widths: prescaler is $clog2(CLK_PER_SEC) bits. remaining_sec never underflows; decrement only when nonzero.

Test Plan (CLK_PER_SEC=4, HURRICANE_SEC=3):
- Reset with machine_state=1, mode_state=0 → enabled=1, return_state=0, remaining_sec=0, countdown_active=0.
- Drive mode_state=3 → next cycle remaining_sec=3, countdown_active=1. remaining_sec reads 2, 1 at 4-cycle intervals. enabled=0 and countdown_active=0 exactly 12 cycles after RUN entry; return_state=0.
- As above, pulse menu_btn (0→1→0) at cycle 5 of RUN → return_state=1 from the next cycle through EXIT. Drive mode_state=2 → return_state=0, state USED, enabled stays 0.
- After USED, drive mode_state=3 again → enabled stays 0, remaining_sec stays 0. Toggle machine_state 1→0→1 → enabled=1; a new run loads remaining_sec=3.
- menu_rise coincident with final prescaler tick → enabled=0 and return_state=1 on the same edge.
- Mid-RUN, deassert machine_state at cycle 6 → next edge all outputs at reset values. Separately, assert rst=0 mid-RUN → outputs reset immediately, without waiting for clk.
